// File: rtl/ciphertext_fifo.sv
// First-word-fall-through buffer between the encryption core and the byte consumer.
// Rejected (invalid-plaintext) bytes are dropped and tallied in a saturating counter.
module ciphertext_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        Char_ciphertext,
    input  logic                     C_ready,
    input  logic                     err_invalid_ptxt,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              err_hit;

    // Status flags come only from registered count, never from the handshakes.
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    assign push_req = C_ready & ~err_invalid_ptxt;
    assign err_hit  = C_ready & err_invalid_ptxt;
    assign pop      = out_valid & out_ready;
    // When full, a push only fits if the head leaves in the same cycle.
    assign push     = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= Char_ciphertext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
            if (err_hit && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ciphertext_fifo.sv
// Directed bench for ciphertext_fifo: hand-computed vectors for fill, overflow,
// full push+pop, error saturation, clear, wrap-around and mid-stream reset.
module tb_ciphertext_fifo;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] Char_ciphertext;
    logic       C_ready;
    logic       err_invalid_ptxt;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] err_count;

    int n_vec  = 0;
    int n_miss = 0;

    ciphertext_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (clear),
        .Char_ciphertext  (Char_ciphertext),
        .C_ready          (C_ready),
        .err_invalid_ptxt (err_invalid_ptxt),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .overflow         (overflow),
        .err_count        (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        Char_ciphertext = b;
        C_ready = 1'b1;
        step();
        C_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        Char_ciphertext = 8'h00;
        C_ready = 1'b0;
        err_invalid_ptxt = 1'b0;
        out_ready = 1'b0;
        #23;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err_count, 0);
        rst_n = 1'b1;
        step();

        // 1: single push, held without out_ready
        push_byte(8'hA5);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 8'hA5);
        chk("t1_count", count, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_hold_data", out_data, 8'hA5);
            chk("t1_hold_valid", out_valid, 1);
        end
        do_clear();
        chk("t1_clr_empty", empty, 1);

        // 2: fill, overflow, drain in order
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("t2_full", full, 1);
        chk("t2_count", count, 16);
        chk("t2_ovf_pre", overflow, 0);
        push_byte(8'hFF);
        chk("t2_ovf", overflow, 1);
        chk("t2_count_ovf", count, 16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain", out_data, 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("t2_empty", empty, 1);
        chk("t2_ovf_sticky", overflow, 1);
        do_clear();
        chk("t2_ovf_clr", overflow, 0);

        // 3: push and pop together while full
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        Char_ciphertext = 8'h77;
        C_ready = 1'b1;
        out_ready = 1'b1;
        step();
        C_ready = 1'b0;
        out_ready = 1'b0;
        chk("t3_count", count, 16);
        chk("t3_ovf", overflow, 0);
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("t3_drain", out_data, 32'(i));
            step();
        end
        chk("t3_last", out_data, 8'h77);
        step();
        out_ready = 1'b0;
        chk("t3_empty", empty, 1);

        // 4: error flag without C_ready is ignored; with C_ready saturates
        err_invalid_ptxt = 1'b1;
        step();
        chk("t4_err_ign", err_count, 0);
        Char_ciphertext = 8'h3C;
        C_ready = 1'b1;
        step();
        chk("t4_err_one", err_count, 1);
        for (int i = 0; i < 299; i++) step();
        C_ready = 1'b0;
        err_invalid_ptxt = 1'b0;
        chk("t4_err_sat", err_count, 255);
        chk("t4_count", count, 0);
        chk("t4_empty", empty, 1);

        // 5: clear wins over a same-cycle push
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        chk("t5_count5", count, 5);
        Char_ciphertext = 8'h99;
        C_ready = 1'b1;
        clear = 1'b1;
        step();
        C_ready = 1'b0;
        clear = 1'b0;
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_ovf", overflow, 0);
        chk("t5_err", err_count, 0);
        chk("t5_data", out_data, 0);
        push_byte(8'h42);
        chk("t5_sole_count", count, 1);
        chk("t5_sole_data", out_data, 8'h42);
        out_ready = 1'b1;
        step();
        chk("t5_sole_pop", empty, 1);

        // 6: streaming through the pointer wrap
        for (int k = 0; k < 40; k++) begin
            Char_ciphertext = 8'(k * 7 + 3);
            C_ready = 1'b1;
            step();
            chk("t6_data", out_data, 32'((k * 7 + 3) & 8'hFF));
            chk("t6_count", count, 1);
        end
        C_ready = 1'b0;
        step();
        chk("t6_empty", empty, 1);
        out_ready = 1'b0;

        // 7: asynchronous reset mid-stream discards contents
        for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_count", count, 0);
        chk("t7_rst_valid", out_valid, 0);
        rst_n = 1'b1;
        step();
        push_byte(8'h5A);
        chk("t7_first", out_data, 8'h5A);
        chk("t7_count", count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
